// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Stalling bridge between the CPU datapath and a request/acknowledge memory
// bus. A load (mem_rd) or store (wea != 0) seen in IDLE is latched and issued
// as a single bus transfer in BUSY. The transfer ends on ack, on error, or
// after TIMEOUT BUSY cycles. A one-cycle DONE state then releases the stall
// and carries the access_fault pulse.
//
// Parameters
//   TIMEOUT       maximum BUSY cycles to wait for bus_ack before faulting
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous reset, active low
//   mem_rd        load request from the datapath
//   addr          byte address (ALU_out)
//   wdata         lane-aligned store data (Data_out)
//   wea           byte-lane write enables, nonzero means store
//   stall         freezes PC / register writeback (combinational)
//   rdata         last successfully loaded word (Data_in)
//   access_fault  one-cycle pulse on bus error or timeout
//   bus_req       transfer valid toward memory
//   bus_we        write strobe
//   bus_be        byte enables
//   bus_addr      word-aligned address
//   bus_wdata     write data
//   bus_rdata     read data, valid with bus_ack
//   bus_ack       memory completes the transfer
//   bus_err       memory reports an error
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_rd,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  wea,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        access_fault,
   output logic        bus_req,
   output logic        bus_we,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   input  logic        bus_err
);

   // Counter only needs to reach TIMEOUT-1.
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  wait_q, wait_d;
   logic [31:2]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [3:0]        be_q, be_d;
   logic              we_q, we_d;
   logic              fault_q, fault_d;

   logic              req_in;
   logic              timeout_hit;
   logic              addr_lsb_unused;

   assign req_in      = mem_rd | (|wea);
   assign timeout_hit = (wait_q == CNT_W'(TIMEOUT - 1));

   // The bus is word addressed; byte offset is already encoded in wea.
   assign addr_lsb_unused = ^addr[1:0];

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         wait_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         be_q    <= '0;
         we_q    <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         be_q    <= be_d;
         we_q    <= we_d;
         fault_q <= fault_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      be_d    = be_q;
      we_d    = we_q;
      fault_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_in) begin
               state_d = BUSY;
               wait_d  = '0;
               addr_d  = addr[31:2];
               wdata_d = wdata;
               // A store wins over a simultaneous load.
               if (|wea) begin
                  be_d = wea;
                  we_d = 1'b1;
               end else begin
                  be_d = 4'b1111;
                  we_d = 1'b0;
               end
            end
         end
         BUSY: begin
            // Priority: error, then ack, then timeout.
            if (bus_err) begin
               state_d = DONE;
               fault_d = 1'b1;
            end else if (bus_ack) begin
               state_d = DONE;
               if (!we_q) begin
                  rdata_d = bus_rdata;
               end
            end else if (timeout_hit) begin
               state_d = DONE;
               fault_d = 1'b1;
            end else begin
               wait_d = wait_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs
   always_comb begin
      stall   = 1'b0;
      bus_req = 1'b0;
      bus_we  = 1'b0;
      bus_be  = 4'b0000;
      case (state_q)
         IDLE: stall = req_in;
         BUSY: begin
            stall   = 1'b1;
            bus_req = 1'b1;
            bus_we  = we_q;
            bus_be  = be_q;
         end
         default: stall = 1'b0;
      endcase
   end

   assign bus_addr     = {addr_q, 2'b00};
   assign bus_wdata    = wdata_q;
   assign rdata        = rdata_q;
   assign access_fault = fault_q;

endmodule
